// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: next-PC generation, imem read requests, valid/ready hand-off to decode.
// Latency: REQ -> WAIT -> HOLD; with 1-cycle memory ready and response, 3 cycles per instruction.
// Backpressure: holds PC and the fetched word while decode stalls; optional FETCH_ALIGN_CHECK_EN rejects misaligned redirects.
module fetch_sequencer #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        align_fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   misaligned;
    logic   redir_ok;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (redirect_target[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A redirect only takes effect outside IDLE and, if checked, when word aligned.
    assign redir_ok  = redirect_valid && (state != IDLE) && !misaligned;
    assign imem_addr = pc_in;

    // Next PC: redirect beats sequential advance; otherwise the PC register holds.
    always_comb begin
        pc_next = pc_in;
        if (reset) begin
            pc_next = pc_in;
        end else if (redir_ok) begin
            pc_next = redirect_target;
        end else if (state == WAIT && imem_rsp_valid) begin
            pc_next = pc_in + PC_STEP[31:0];
        end
    end

    // Next-state decode, including redirect handling in each state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = REQ;
            REQ: begin
                if (imem_req_ready) begin
                    // A request already left at the old PC; its response must be dropped.
                    state_nxt = redir_ok ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_nxt = redir_ok ? REQ : HOLD;
                end else if (redir_ok) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD: begin
                if (redir_ok || instr_ready) begin
                    state_nxt = REQ;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register with registered handshake outputs and fetched-word capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= 32'd0;
            instr_pc       <= 32'd0;
            fetch_count    <= 32'd0;
        end else begin
            state          <= state_nxt;
            imem_req_valid <= (state_nxt == REQ);
            instr_valid    <= (state_nxt == HOLD);
            if (state == WAIT && imem_rsp_valid && !redir_ok) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc_in;
            end
            // A redirect in HOLD drops the word uncounted even if decode is ready.
            if (state == HOLD && instr_ready && !redir_ok) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // One-cycle pulse for each rejected misaligned redirect.
    always_ff @(posedge clock) begin
        if (reset) begin
            align_fault <= 1'b0;
        end else begin
            align_fault <= redirect_valid && (state != IDLE) && misaligned;
        end
    end
`else
    assign align_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Each scenario task checks its own expected values inline.
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        align_fault;
    logic [31:0] fetch_count;

    int total = 0;
    int bad   = 0;

    fetch_sequencer #(.PC_STEP(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_in           (pc),
        .pc_next         (pc_next),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .align_fault     (align_fault),
        .fetch_count     (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The PC register outside the block: latches pc_next every edge, clears on reset.
    always @(posedge clock) begin
        if (reset) pc <= 32'd0;
        else       pc <= pc_next;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
        total++; if (instr !== 32'd0 || instr_pc !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h/%h exp=0/0", instr, instr_pc); end
        total++; if (align_fault !== 1'b0) begin bad++; $display("FAIL reset_align got=%b exp=0", align_fault); end
        total++; if (pc_next !== 32'd0) begin bad++; $display("FAIL reset_pc_next got=%h exp=0", pc_next); end
        reset = 1'b0;
        step();
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] words [3];
        words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
        for (int i = 0; i < 3; i++) begin
            total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'(i * 4)) begin bad++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, imem_req_valid, imem_addr, i * 4); end
            imem_req_ready = 1'b1;
            step();
            imem_req_ready = 1'b0;
            total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL seq_wait%0d got=%b/%b exp=0/0", i, imem_req_valid, instr_valid); end
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = words[i];
            #1;
            total++; if (pc_next !== 32'(i * 4 + 4)) begin bad++; $display("FAIL seq_pc_next%0d got=%h exp=%h", i, pc_next, i * 4 + 4); end
            step();
            imem_rsp_valid = 1'b0;
            total++; if (instr_valid !== 1'b1 || instr !== words[i] || instr_pc !== 32'(i * 4)) begin bad++; $display("FAIL seq_hold%0d got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, instr_pc, words[i], i * 4); end
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            total++; if (fetch_count !== 32'(i + 1)) begin bad++; $display("FAIL seq_count%0d got=%0d exp=%0d", i, fetch_count, i + 1); end
        end
    endtask

    task automatic test_hold_stall();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h44;
        step();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (instr_valid !== 1'b1 || instr !== 32'h44 || pc_next !== 32'h10 || imem_req_valid !== 1'b0) begin
                bad++; $display("FAIL stall%0d got=%b/%h/%h/%b exp=1/44/10/0", i, instr_valid, instr, pc_next, imem_req_valid);
            end
            step();
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total++; if (fetch_count !== 32'd4 || imem_addr !== 32'h10 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_exit got=%0d/%h/%b exp=4/10/1", fetch_count, imem_addr, imem_req_valid); end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        #1;
        total++; if (pc_next !== 32'h100) begin bad++; $display("FAIL rdw_pc_next got=%h exp=100", pc_next); end
        step();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL rdw_drain got=%b/%b exp=0/0", imem_req_valid, instr_valid); end
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD;
        #1;
        total++; if (pc_next !== 32'h100) begin bad++; $display("FAIL rdw_drain_pc got=%h exp=100", pc_next); end
        step();
        imem_rsp_valid = 1'b0;
        total++; if (instr_valid !== 1'b0 || instr === 32'hDEAD) begin bad++; $display("FAIL rdw_stale got=%b/%h exp=0/not DEAD", instr_valid, instr); end
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL rdw_req got=%b/%h exp=1/100", imem_req_valid, imem_addr); end
    endtask

    task automatic test_redirect_same_rsp();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'hBEEF;
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        #1;
        total++; if (pc_next !== 32'h40) begin bad++; $display("FAIL rds_pc_next got=%h exp=40", pc_next); end
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0 || instr !== 32'h44) begin bad++; $display("FAIL rds_discard got=%b/%h exp=0/44", instr_valid, instr); end
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL rds_req got=%b/%h exp=1/40", imem_req_valid, imem_addr); end
    endtask

    task automatic test_hold_redirect();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h77;
        step();
        imem_rsp_valid  = 1'b0;
        instr_ready     = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        step();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        total++; if (fetch_count !== 32'd4 || instr_valid !== 1'b0) begin bad++; $display("FAIL hrd_drop got=%0d/%b exp=4/0", fetch_count, instr_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL hrd_req got=%b/%h exp=1/200", imem_req_valid, imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req got=%b/%h exp=1/fffffffc", imem_req_valid, imem_addr); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h55;
        #1;
        total++; if (pc_next !== 32'd0) begin bad++; $display("FAIL wrap_pc_next got=%h exp=0", pc_next); end
        step();
        imem_rsp_valid = 1'b0;
        total++; if (instr !== 32'h55 || instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_hold got=%h/%h exp=55/fffffffc", instr, instr_pc); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total++; if (imem_addr !== 32'd0 || fetch_count !== 32'd5) begin bad++; $display("FAIL wrap_next got=%h/%0d exp=0/5", imem_addr, fetch_count); end
    endtask

    task automatic test_align();
        logic [31:0] exp_pc;
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_pc = 32'h0;
`else
        exp_pc = 32'h102;
`endif
        #1;
        total++; if (pc_next !== exp_pc) begin bad++; $display("FAIL align_pc_next got=%h exp=%h", pc_next, exp_pc); end
        step();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        total++; if (align_fault !== 1'b1) begin bad++; $display("FAIL align_pulse got=%b exp=1", align_fault); end
`else
        total++; if (align_fault !== 1'b0) begin bad++; $display("FAIL align_off got=%b exp=0", align_fault); end
`endif
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin bad++; $display("FAIL align_req got=%b/%h exp=1/%h", imem_req_valid, imem_addr, exp_pc); end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        total++; if (align_fault !== 1'b0) begin bad++; $display("FAIL align_one_cycle got=%b exp=0", align_fault); end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h66;
        step();
        imem_rsp_valid = 1'b0;
        total++; if (instr !== 32'h66 || instr_pc !== exp_pc) begin bad++; $display("FAIL align_hold got=%h/%h exp=66/%h", instr, instr_pc, exp_pc); end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        total++; if (imem_addr !== exp_pc + 32'd4 || fetch_count !== 32'd6) begin bad++; $display("FAIL align_seq got=%h/%0d exp=%h/6", imem_addr, fetch_count, exp_pc + 32'd4); end
    endtask

    task automatic test_mid_reset();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (pc_next !== pc) begin bad++; $display("FAIL mrst_pc_next got=%h exp=%h", pc_next, pc); end
        step();
        total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 32'd0 || pc !== 32'd0) begin
            bad++; $display("FAIL mrst_state got=%b/%b/%0d/%h exp=0/0/0/0", imem_req_valid, instr_valid, fetch_count, pc);
        end
        reset = 1'b0;
        step();
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'd0) begin bad++; $display("FAIL mrst_restart got=%b/%h exp=1/0", imem_req_valid, imem_addr); end
    endtask

    initial begin
        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'd0;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_same_rsp();
        test_hold_redirect();
        test_wrap();
        test_align();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
